// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue controller: ALU select codes,
// MIPS opcode/funct values, FSM states and the decode record.
package alu_issue_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    SEL_AND = 4'd0,
    SEL_OR  = 4'd1,
    SEL_ADD = 4'd2,
    SEL_SUB = 4'd3,
    SEL_SLT = 4'd4,
    SEL_SLL = 4'd5,
    SEL_SRL = 4'd6,
    SEL_SRA = 4'd7,
    SEL_XOR = 4'd9,
    SEL_NOR = 4'd10,
    SEL_NOP = 4'd15
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  // IMM_NONE means data_2 comes from the rt register
  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SEXT = 2'd1,
    IMM_ZEXT = 2'd2
  } imm_mode_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    alu_sel_e   sel;
    imm_mode_e  imm_mode;
    logic       zero_d1;
    logic [4:0] shamt;
    logic [4:0] dest;
    logic       illegal;
  } dec_t;

  function automatic logic [31:0] ext_imm(input imm_mode_e m, input logic [15:0] imm);
    return (m == IMM_SEXT) ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of one MIPS R-type / ALU-immediate word into ALU controls.
// Optional macro ALU_ISSUE_LUI_EN: decode LUI as SLL of the zero-extended imm by 16.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       unused_rs;

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign rt        = instr[20:16];
  assign unused_rs = ^instr[25:21];

  alu_sel_e  sel;
  imm_mode_e imm;
  logic      shift;
  logic [4:0] shamt;
  logic [4:0] dest;
  logic      ok;

  always_comb begin
    sel   = SEL_NOP;
    imm   = IMM_NONE;
    shift = 1'b0;
    shamt = 5'd0;
    dest  = 5'd0;
    ok    = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        dest = instr[15:11];
        case (funct)
          FN_AND:          sel = SEL_AND;
          FN_OR:           sel = SEL_OR;
          FN_ADD, FN_ADDU: sel = SEL_ADD;
          FN_SUB, FN_SUBU: sel = SEL_SUB;
          FN_SLT:          sel = SEL_SLT;
          FN_XOR:          sel = SEL_XOR;
          FN_NOR:          sel = SEL_NOR;
          FN_SLL: begin sel = SEL_SLL; shift = 1'b1; shamt = instr[10:6]; end
          FN_SRL: begin sel = SEL_SRL; shift = 1'b1; shamt = instr[10:6]; end
          FN_SRA: begin sel = SEL_SRA; shift = 1'b1; shamt = instr[10:6]; end
          default: ok = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin sel = SEL_ADD; imm = IMM_SEXT; dest = rt; end
      OP_SLTI:           begin sel = SEL_SLT; imm = IMM_SEXT; dest = rt; end
      OP_ANDI:           begin sel = SEL_AND; imm = IMM_ZEXT; dest = rt; end
      OP_ORI:            begin sel = SEL_OR;  imm = IMM_ZEXT; dest = rt; end
      OP_XORI:           begin sel = SEL_XOR; imm = IMM_ZEXT; dest = rt; end
`ifdef ALU_ISSUE_LUI_EN
      OP_LUI: begin
        sel = SEL_SLL; imm = IMM_ZEXT; shift = 1'b1; shamt = 5'd16; dest = rt;
      end
`endif
      default: ok = 1'b0;
    endcase

    // Undecodable words collapse to a NOP with no destination
    if (!ok) begin
      sel   = SEL_NOP;
      imm   = IMM_NONE;
      shift = 1'b1;
      shamt = 5'd0;
      dest  = 5'd0;
    end

    dec.sel      = sel;
    dec.imm_mode = imm;
    dec.zero_d1  = shift;
    dec.shamt    = shamt;
    dec.dest     = dest;
    dec.illegal  = !ok;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller feeding the ALU and the register-file write port.
// Optional macro ALU_ISSUE_LUI_EN enables LUI decode (see alu_issue_decode).
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [3:0]        alu_sel,
  output logic [4:0]        alu_shamt,
  output logic [DATA_W-1:0] alu_data_1,
  output logic [DATA_W-1:0] alu_data_2,
  input  logic [DATA_W-1:0] alu_out,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal
);

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic              ready_q, ready_d;
  alu_sel_e          sel_q, sel_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [DATA_W-1:0] d1_q, d1_d;
  logic [DATA_W-1:0] d2_q, d2_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              ill_pend_q, ill_pend_d;
  logic              wb_en_q, wb_en_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              illegal_q, illegal_d;

  dec_t dec;

  alu_issue_decode u_decode (
    .instr (ir_q),
    .dec   (dec)
  );

  assign rs_addr = ir_q[25:21];
  assign rt_addr = ir_q[20:16];

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    sel_d      = sel_q;
    shamt_d    = shamt_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    dest_d     = dest_q;
    ill_pend_d = ill_pend_q;
    wb_data_d  = wb_data_q;
    wb_en_d    = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && ready_q) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        sel_d      = dec.sel;
        shamt_d    = dec.shamt;
        dest_d     = dec.dest;
        ill_pend_d = dec.illegal;
        d1_d       = dec.zero_d1 ? '0 : rs_data;
        d2_d       = (dec.imm_mode == IMM_NONE) ? rt_data : ext_imm(dec.imm_mode, ir_q[15:0]);
        if (dec.illegal) begin
          d1_d = '0;
          d2_d = '0;
        end
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        wb_data_d = alu_out;
        wb_en_d   = !ill_pend_q && (dest_q != '0);
        illegal_d = ill_pend_q;
        state_d   = ST_WB;
      end
      default: state_d = ST_IDLE;
    endcase
    // Ready is a registered flag so it can leave reset low and rise one edge later
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      ready_q    <= 1'b0;
      sel_q      <= SEL_AND;
      shamt_q    <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      dest_q     <= '0;
      ill_pend_q <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ready_q    <= ready_d;
      sel_q      <= sel_d;
      shamt_q    <= shamt_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      dest_q     <= dest_d;
      ill_pend_q <= ill_pend_d;
      wb_en_q    <= wb_en_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
    end
  end

  assign instr_ready = ready_q;
  assign alu_sel     = sel_q;
  assign alu_shamt   = shamt_q;
  assign alu_data_1  = d1_q;
  assign alu_data_2  = d2_q;
  assign wb_en       = wb_en_q;
  assign wb_addr     = dest_q;
  assign wb_data     = wb_data_q;
  assign illegal     = illegal_q;

endmodule
